// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_tx among NUM_REQ byte sources.
// Optional watchdog on a stuck frame: define UART_TX_ARB_TIMEOUT_EN.

module uart_tx_arb_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic grant,
    output logic ack
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack <= 1'b0;
        else        ack <= grant;
    end
endmodule

module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       trmt,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic                       busy,
    output logic                       tx_err
);
    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8, TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic {IDLE, BUSY} state_t;
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     data;
    } sel_t;

    state_t                  state;
    logic [IDW-1:0]          ptr;
    logic [NUM_REQ-1:0][7:0] data_arr;
    logic [NUM_REQ-1:0]      hi_mask;
    logic [NUM_REQ-1:0]      pick;
    logic [IDW-1:0]          win;
    sel_t                    sel;
    logic                    grant_now;
    logic                    done_ok;
    logic                    wdog_hit;

    assign data_arr = req_data;

    // Requesters above ptr get first look; if none, wrap to the lowest index.
    always_comb begin
        hi_mask = '0;
        for (int j = 0; j < NUM_REQ; j++)
            hi_mask[j] = (IDW'(j) > ptr);
        pick = ((req & hi_mask) != '0) ? (req & hi_mask) : req;
        win  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--)
            if (pick[j]) win = IDW'(j);
    end

    assign sel.id    = win;
    assign sel.data  = data_arr[win];
    assign grant_now = (state == IDLE) && (req != '0);
    // tx_done coinciding with our own trmt cannot belong to this frame.
    assign done_ok   = (state == BUSY) && tx_done && !trmt;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        uart_tx_arb_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .grant (grant_now && (win == IDW'(i))),
            .ack   (ack[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            trmt    <= 1'b0;
            busy    <= 1'b0;
            tx_data <= 8'h00;
            gnt_id  <= IDW'(NUM_REQ - 1);
            ptr     <= IDW'(NUM_REQ - 1);
        end else begin
            trmt <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        tx_data <= sel.data;
                        gnt_id  <= sel.id;
                        ptr     <= sel.id;
                        trmt    <= 1'b1;
                        busy    <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (done_ok || wdog_hit) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES);
    logic [WDW-1:0] wdog;

    assign wdog_hit = (state == BUSY) && !done_ok && (wdog == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog   <= '0;
            tx_err <= 1'b0;
        end else begin
            if (grant_now)           wdog <= '0;
            else if (state == BUSY)  wdog <= wdog + WDW'(1);
            if (wdog_hit)            tx_err <= 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign tx_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants queued at stimulus, checked on trmt.

module tb_uart_tx_arbiter;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 131072;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [1:0]  gnt_id;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic        tx_err;

    typedef struct { int id; int data; } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_err = 0;
    int cyc = 0, lat_exp = -1, trmt_cyc = 0, n_trmt = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .gnt_id   (gnt_id),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .tx_err   (tx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int data);
        exp_t e;
        e.id = id; e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_trmt();
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            tick(1);
            seen = trmt;
        end
        if (!seen) chk("trmt_timeout", 32'd0, 32'd1);
    endtask

    task automatic done_pulse(input bit expect_next);
        tx_done = 1'b1;
        lat_exp = expect_next ? cyc : -1;
        tick(1);
        tx_done = 1'b0;
    endtask

    task automatic check_reset(input string p);
        chk({p, "_ack"}, ack, 0);
        chk({p, "_trmt"}, trmt, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_txdata"}, tx_data, 0);
        chk({p, "_gnt"}, gnt_id, 3);
        chk({p, "_err"}, tx_err, 0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; req = '0; tx_done = 1'b0;
        tick(2);
        check_reset("rst");
        rst_n = 1'b1; lat_exp = -1; n_trmt = 0;
        tick(1);
    endtask

    // Monitor: every trmt must match the oldest queued grant.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (trmt) begin
                exp_t e;
                n_trmt++;
                trmt_cyc = cyc;
                if (sb.size() == 0) chk("unexp_trmt", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("gnt_id", gnt_id, e.id);
                    chk("tx_data", tx_data, e.data);
                    chk("ack", ack, 32'd1 << e.id);
                    chk("busy_on_trmt", busy, 1);
                    if (lat_exp >= 0) chk("trmt_lat", cyc - lat_exp, 2);
                end
                lat_exp = -1;
            end else if (ack != 0) begin
                chk("stray_ack", ack, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        req_data = '0;
        // single requester 2
        reset_dut();
        req = 4'b0100; req_data = 32'h0047_0000;
        push(2, 8'h47);
        wait_trmt();
        req = '0; req_data[23:16] = 8'h99;
        tick(10);
        chk("hold_txdata", tx_data, 8'h47);
        chk("hold_busy", busy, 1);
        chk("one_trmt", n_trmt, 1);
        done_pulse(0);
        chk("release_busy", busy, 0);

        // all requesting: 0,1,2,3,0
        reset_dut();
        req_data = 32'hA3A2_A1A0;
        for (int i = 0; i < 5; i++) push(i % 4, 8'hA0 + (i % 4));
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_trmt();
            tick(19);
            if (i == 4) req = '0;
            done_pulse(i < 4);
        end
        chk("rr_trmt_count", n_trmt, 5);

        // ptr wrap from 1 to 0
        tick(3);
        req = 4'b0010; req_data = 32'h0000_B100;
        push(1, 8'hB1);
        wait_trmt();
        req = 4'b0011; req_data = 32'h0000_C1C0;
        push(0, 8'hC0);
        push(1, 8'hC1);
        tick(5);
        done_pulse(1);
        wait_trmt();
        req = 4'b0010;
        tick(5);
        done_pulse(1);
        wait_trmt();
        req = '0;
        tick(5);
        done_pulse(0);

        // stray tx_done in IDLE and in the trmt cycle
        tick(2);
        done_pulse(0);
        tick(2);
        chk("idle_done_busy", busy, 0);
        req = 4'b1000; req_data = 32'hD300_0000;
        push(3, 8'hD3);
        wait_trmt();
        req = '0;
        done_pulse(0);
        chk("early_done_busy", busy, 1);
        tick(5);
        chk("still_busy", busy, 1);
        done_pulse(0);
        chk("late_done_busy", busy, 0);

        // reset mid-frame
        req = 4'b0001; req_data = 32'h0000_00E0;
        push(0, 8'hE0);
        wait_trmt();
        tick(3);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        tick(1);
        rst_n = 1'b1; lat_exp = -1;
        push(0, 8'hE0);
        wait_trmt();
        req = '0;
        tick(3);
        done_pulse(0);

`ifdef UART_TX_ARB_TIMEOUT_EN
        tick(2);
        req = 4'b0100; req_data = 32'h0066_0000;
        push(2, 8'h66);
        wait_trmt();
        req = '0;
        begin
            bit fell = 1'b0;
            for (int i = 0; i < 200 && !fell; i++) begin
                tick(1);
                fell = !busy;
            end
            if (!fell) chk("wdog_timeout", 32'd0, 32'd1);
            else begin
                @(negedge clk);
                chk("wdog_delay", cyc - trmt_cyc, TO);
            end
        end
        chk("tx_err_set", tx_err, 1);
        tick(5);
        chk("tx_err_sticky", tx_err, 1);
        req = 4'b0001; req_data = 32'h0000_0077;
        push(0, 8'h77);
        wait_trmt();
        req = '0;
        chk("tx_err_kept", tx_err, 1);
        tick(3);
        done_pulse(0);
        chk("after_wdog_busy", busy, 0);
`else
        chk("tx_err_off", tx_err, 0);
`endif

        tick(3);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART_tx transmitter toward the BLE module among NUM_REQ on-chip byte sources: auth acks, telemetry, fault reports. Round-robin arbitration picks one request, latches its byte, pulses trmt, and holds further grants until UART_tx reports tx_done. It sits between the requesting blocks and UART_tx (50MHz, 9600 baud), mirroring the Auth_blk/UART_rx pairing on the receive side.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
TIMEOUT_CYCLES, 131072, watchdog limit in clk cycles while BUSY; used only with UART_TX_ARB_TIMEOUT_EN. One 10-bit frame at 9600 baud is 52083 cycles.

Ports:
clk  input  1  50MHz system clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester send request, level; bit 0 is requester 0
req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
ack  output  NUM_REQ  one-cycle pulse; byte i accepted
gnt_id  output  $clog2(NUM_REQ)  index of last granted requester
trmt  output  1  one-cycle start pulse to UART_tx
tx_data  output  8  byte to UART_tx, stable from trmt until next grant
tx_done  input  1  one-cycle completion pulse from UART_tx
busy  output  1  high from trmt until the cycle after tx_done is accepted
tx_err  output  1  sticky watchdog error; tied 0 without UART_TX_ARB_TIMEOUT_EN

Behaviour:
- Reset, asynchronous: state IDLE, ack=0, trmt=0, busy=0, tx_data=8'h00, gnt_id=NUM_REQ-1, rr pointer=NUM_REQ-1, tx_err=0, watchdog counter=0.
- All outputs are registered.
- States:
  - IDLE: combinationally select the winner among asserted req bits. Search order is ptr+1, ptr+2, ... wrapping modulo NUM_REQ.
  - IDLE with any req at edge: tx_data<=req_data[winner], trmt<=1, ack[winner]<=1, gnt_id<=winner, ptr<=winner, busy<=1, go to BUSY.
  - IDLE with no req: stay; all pulses 0.
  - BUSY: trmt and ack drop after 1 cycle. tx_done is ignored in the first BUSY cycle, while trmt=1. A later tx_done returns to IDLE and busy<=0.
- Latency:
  - req sampled in IDLE at cycle k produces trmt and ack at cycle k+1.
  - tx_done at cycle m gives IDLE at m+1. The earliest next trmt is m+2.
- Handshake:
  - Requester holds req and req_data stable until it sees ack.
  - Requester deasserts req in the cycle after ack, unless it has another byte.
  - req is never sampled in BUSY, so a held req simply waits.
  - A req dropped before grant is lost without error.
- Fairness: a requester that was just granted has lowest priority next round. With all req high the grant order is 0,1,2,...,NUM_REQ-1,0.
- Boundaries:
  - tx_done while IDLE: ignored.
  - req change during BUSY: no effect on tx_data.
  - Single requester continuously asserted: granted every frame.
  - ptr wraps from NUM_REQ-1 to 0.
- Reset mid-frame: returns to IDLE immediately with no ack or trmt. UART_tx shares rst_n and aborts its frame.

Optional Feature:
UART_TX_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES-1 without tx_done, go to IDLE, busy<=0, and set sticky tx_err<=1.
  - tx_err clears only on rst_n. Arbitration continues normally after a timeout.
- Undefined: no counter; BUSY waits indefinitely for tx_done; tx_err constant 0.

Test Plan:
1. Reset, then req=4'b0100 with req_data[23:16]=8'h47 -> next cycle trmt=1, ack=4'b0100, tx_data=8'h47, gnt_id=2, busy=1; no second trmt before tx_done.
2. req=4'b1111 held, with bytes 8'hA0..8'hA3 and tx_done pulsed 20 cycles after each trmt -> grant order 0,1,2,3,0; exactly one ack per trmt.
3. Grant to requester 1, then req=4'b0011 -> next grant goes to 0 (ptr wrap), then 1; tx_done at m gives trmt at m+2.
4. tx_done pulsed while IDLE, and again in the trmt cycle -> no state change or early release; busy stays 1 until a later tx_done.
5. Assert rst_n=0 mid-BUSY for 1 cycle, with req=4'b0001 held -> outputs return to reset values; after release the first trmt goes to requester 0.
6. (UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100) grant with no tx_done -> busy falls 100 cycles after trmt, tx_err=1 and stays 1; the next req is still granted.
